// File: rtl/usbf_pa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usbf_pa_pkg
//  Description : Shared definitions for the USB function packet assembler:
//                PID codes, one-hot FSM encoding, CRC16 constants and small
//                PID helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package usbf_pa_pkg;

   // 4-bit PID codes; the byte on the wire is {~pid, pid}
   localparam logic [3:0] c_PID_ACK   = 4'h2;
   localparam logic [3:0] c_PID_NACK  = 4'hA;
   localparam logic [3:0] c_PID_STALL = 4'hE;
   localparam logic [3:0] c_PID_NYET  = 4'h6;
   localparam logic [3:0] c_PID_DATA0 = 4'h3;
   localparam logic [3:0] c_PID_DATA1 = 4'hB;
   localparam logic [3:0] c_PID_DATA2 = 4'h7;
   localparam logic [3:0] c_PID_MDATA = 4'hF;

   // CRC16 x^16+x^15+x^2+1. The register is kept in reflected (LSB-first)
   // form, so its low bit is the coefficient of x^15 and each byte of the
   // inverted register is already in USB wire order.
   localparam logic [15:0] c_CRC16_PRESET        = 16'hFFFF;
   localparam logic [15:0] c_CRC16_POLY_REFL     = 16'hA001;
   // Good-packet residual: 16'h800D in polynomial order, 16'hB001 as seen in
   // the reflected register of usbf_crc16 on the receive path.
   localparam logic [15:0] c_CRC16_RESIDUAL      = 16'h800D;
   localparam logic [15:0] c_CRC16_RESIDUAL_REFL = 16'hB001;

   // One-hot transmit FSM encoding
   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_PID    = 5'b00010,
      S_DATA   = 5'b00100,
      S_CRC_LO = 5'b01000,
      S_CRC_HI = 5'b10000
   } pa_state_t;

   // Handshake selector -> PID
   function automatic logic [3:0] hs_pid(input logic [1:0] sel);
      logic [3:0] pid;
      case (sel)
         2'd0:    pid = c_PID_ACK;
         2'd1:    pid = c_PID_NACK;
         2'd2:    pid = c_PID_STALL;
         default: pid = c_PID_NYET;
      endcase
      return pid;
   endfunction

   // Data selector -> PID
   function automatic logic [3:0] data_pid(input logic [1:0] sel);
      logic [3:0] pid;
      case (sel)
         2'd0:    pid = c_PID_DATA0;
         2'd1:    pid = c_PID_DATA1;
         2'd2:    pid = c_PID_DATA2;
         default: pid = c_PID_MDATA;
      endcase
      return pid;
   endfunction

   // PID byte with its complement check nibble
   function automatic logic [7:0] pid_byte(input logic [3:0] pid);
      return {~pid, pid};
   endfunction

endpackage
`default_nettype wire

// File: rtl/usbf_crc16.sv
`default_nettype none
// ============================================================================
//  Module      : usbf_crc16
//  Description : Combinational one-byte USB CRC16 update, LSB-first, in
//                reflected register form. Shared by transmit and receive.
//  Revision    : 1.0 - initial release
// ============================================================================
module usbf_crc16
   import usbf_pa_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  din,
   output logic [15:0] crc_out
);

   logic [15:0] w_acc;

   // Eight serial LSB-first CRC steps unrolled over the byte
   always_comb begin
      w_acc = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (w_acc[0] ^ din[i]) begin
            w_acc = (w_acc >> 1) ^ c_CRC16_POLY_REFL;
         end else begin
            w_acc = w_acc >> 1;
         end
      end
   end

   assign crc_out = w_acc;

endmodule
`default_nettype wire

// File: rtl/usbf_pa.sv
`default_nettype none
// ============================================================================
//  Module      : usbf_pa
//  Description : USB function packet assembler. Sends handshake packets
//                (PID only) and data packets (PID, payload, CRC16) to the
//                UTMI transmit interface, with payload underrun abort.
//  Options     : USBF_PA_TX_TIMEOUT_EN - abort after 255 stalled cycles and
//                pulse tx_timeout (otherwise tx_timeout is tied low).
//  Revision    : 1.0 - initial release
// ============================================================================
module usbf_pa
   import usbf_pa_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic       send_hs,
   input  logic [1:0] hs_sel,
   input  logic       send_data,
   input  logic [1:0] data_sel,
   input  logic       zlp,
   input  logic [7:0] data_st,
   input  logic       data_avail,
   input  logic       data_last,
   output logic       data_rd,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_underrun,
   output logic       tx_timeout
);

   pa_state_t   r_state;
   pa_state_t   w_state_nxt;
   logic        r_is_data;
   logic        r_zlp;
   logic [3:0]  r_pid;
   logic [15:0] r_crc;
   logic        r_miss;
   logic        w_miss_nxt;
   logic        w_start;
   logic        w_valid;
   logic        w_timeout;
   logic [15:0] w_crc_nxt;

   assign w_start = send_data | send_hs;

   // Every non-idle state presents a byte, except DATA while memory is empty
   assign w_valid  = (r_state == S_PID) || (r_state == S_CRC_LO) ||
                     (r_state == S_CRC_HI) || ((r_state == S_DATA) && data_avail);
   assign tx_valid = w_valid;
   assign tx_busy  = (r_state != S_IDLE);

   usbf_crc16 u_crc16 (
      .crc_in  (r_crc),
      .din     (data_st),
      .crc_out (w_crc_nxt)
   );

`ifdef USBF_PA_TX_TIMEOUT_EN
   logic [7:0] r_to_cnt;

   // Count consecutive cycles a byte is offered but not taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_to_cnt <= 8'd0;
      end else if (w_valid && !tx_ready && !w_timeout) begin
         r_to_cnt <= r_to_cnt + 8'd1;
      end else begin
         r_to_cnt <= 8'd0;
      end
   end

   assign w_timeout = (r_to_cnt == 8'hFF) && w_valid && !tx_ready;
`else
   assign w_timeout = 1'b0;
`endif

   assign tx_timeout = w_timeout;

   // State register, request capture in IDLE, and CRC accumulation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_is_data <= 1'b0;
         r_zlp     <= 1'b0;
         r_pid     <= 4'h0;
         r_crc     <= c_CRC16_PRESET;
         r_miss    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_miss  <= w_miss_nxt;
         if ((r_state == S_IDLE) && w_start) begin
            r_is_data <= send_data;
            r_zlp     <= send_data & zlp;
            r_pid     <= send_data ? data_pid(data_sel) : hs_pid(hs_sel);
            r_crc     <= c_CRC16_PRESET;
         end else if (data_rd) begin
            r_crc <= w_crc_nxt;
         end
      end
   end

   // Next-state and per-state output decode
   always_comb begin
      w_state_nxt = r_state;
      w_miss_nxt  = 1'b0;
      tx_data     = 8'h00;
      data_rd     = 1'b0;
      tx_done     = 1'b0;
      tx_underrun = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_start) w_state_nxt = S_PID;
         end
         S_PID: begin
            tx_data = pid_byte(r_pid);
            if (tx_ready) begin
               if (!r_is_data) begin
                  tx_done     = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (r_zlp) begin
                  w_state_nxt = S_CRC_LO;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            tx_data = data_st;
            data_rd = data_avail & tx_ready;
            if (!data_avail) begin
               // second empty cycle in a row aborts the packet
               if (r_miss) begin
                  tx_underrun = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_miss_nxt = 1'b1;
               end
            end else if (tx_ready && data_last) begin
               w_state_nxt = S_CRC_LO;
            end
         end
         S_CRC_LO: begin
            tx_data = ~r_crc[7:0];
            if (tx_ready) w_state_nxt = S_CRC_HI;
         end
         S_CRC_HI: begin
            tx_data = ~r_crc[15:8];
            if (tx_ready) begin
               tx_done     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (w_timeout) w_state_nxt = S_IDLE;
   end

endmodule
`default_nettype wire

// File: tb/tb_usbf_pa.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usbf_pa
//  Description : Directed self-checking bench for usbf_pa.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usbf_pa;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic       send_hs = 1'b0;
   logic [1:0] hs_sel = 2'd0;
   logic       send_data = 1'b0;
   logic [1:0] data_sel = 2'd0;
   logic       zlp = 1'b0;
   logic [7:0] data_st = 8'h00;
   logic       data_avail = 1'b0;
   logic       data_last = 1'b0;
   logic       data_rd;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_underrun;
   logic       tx_timeout;

   always #5 clk = ~clk;

   usbf_pa dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .send_hs     (send_hs),
      .hs_sel      (hs_sel),
      .send_data   (send_data),
      .data_sel    (data_sel),
      .zlp         (zlp),
      .data_st     (data_st),
      .data_avail  (data_avail),
      .data_last   (data_last),
      .data_rd     (data_rd),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_underrun (tx_underrun),
      .tx_timeout  (tx_timeout)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference CRC16 in polynomial (MSB-first register) order, wire bits fed LSB-first
   function automatic logic [15:0] crc_std(input logic [15:0] r, input logic [7:0] b);
      logic [15:0] c;
      logic        fb;
      c = r;
      for (int i = 0; i < 8; i++) begin
         fb = c[15] ^ b[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h8005;
      end
      return c;
   endfunction

   // Memory-unit / UTMI model and byte logger
   logic [7:0] pay [0:7];
   int         pay_len  = 0;
   int         rdy_mode = 0;     // 0 always ready, 1 toggle, 2 never ready
   logic       gap_en   = 1'b0;
   int         idx      = 0;
   logic       rd_prev  = 1'b0;
   logic       hold_prev = 1'b0;
   logic [7:0] held     = 8'h00;
   logic [7:0] blog [0:255];
   int         byte_cnt = 0;
   int         rd_cnt   = 0;
   int         done_cnt = 0;
   int         und_cnt  = 0;
   int         stab_viol = 0;

   always @(negedge clk) begin
      if (rd_prev) idx++;
      if (!tx_busy) idx = 0;
      case (rdy_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = 1'b0;
      endcase
      if (idx < pay_len) begin
         data_st    = pay[idx];
         data_last  = (idx == pay_len - 1);
         data_avail = !gap_en;
      end else begin
         data_st    = 8'h00;
         data_last  = 1'b0;
         data_avail = 1'b0;
      end
      #3;
      if (rst && hold_prev && (!tx_valid || tx_data !== held)) stab_viol++;
      hold_prev = rst && tx_valid && !tx_ready && !tx_timeout;
      held      = tx_data;
      if (tx_valid && tx_ready) begin
         blog[byte_cnt[7:0]] = tx_data;
         byte_cnt++;
      end
      rd_prev = rst && data_rd;
      if (data_rd)     rd_cnt++;
      if (tx_done)     done_cnt++;
      if (tx_underrun) und_cnt++;
   end

   task automatic start_hs(input logic [1:0] sel);
      @(posedge clk); #1;
      send_hs = 1'b1; hs_sel = sel;
      @(posedge clk); #1;
      send_hs = 1'b0; hs_sel = ~sel;
   endtask

   task automatic start_data(input logic [1:0] sel, input logic z, input logic hs_too);
      @(posedge clk); #1;
      send_data = 1'b1; data_sel = sel; zlp = z; send_hs = hs_too; hs_sel = 2'd0;
      @(posedge clk); #1;
      send_data = 1'b0; send_hs = 1'b0; data_sel = ~sel; zlp = ~z;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while (tx_busy && k < budget) begin
         @(negedge clk); #4;
         k++;
      end
      check(tag, {31'd0, tx_busy}, 32'd0);
   endtask

   // Check a data packet logged from index base with n payload bytes
   task automatic check_data_pkt(input string tag, input int base, input logic [7:0] pidb, input int n);
      logic [15:0] r;
      logic [15:0] res;
      logic [7:0]  e0;
      logic [7:0]  e1;
      check({tag, "_nbytes"}, byte_cnt - base, n + 3);
      check({tag, "_pid"}, {24'd0, blog[base[7:0]]}, {24'd0, pidb});
      r = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         check({tag, "_payload"}, {24'd0, blog[8'(base + 1 + i)]}, {24'd0, pay[i]});
         r = crc_std(r, pay[i]);
      end
      for (int j = 0; j < 8; j++) begin
         e0[j] = ~r[15 - j];
         e1[j] = ~r[7 - j];
      end
      check({tag, "_crc0"}, {24'd0, blog[8'(base + 1 + n)]}, {24'd0, e0});
      check({tag, "_crc1"}, {24'd0, blog[8'(base + 2 + n)]}, {24'd0, e1});
      res = 16'hFFFF;
      for (int i = 0; i < n + 2; i++) res = crc_std(res, blog[8'(base + 1 + i)]);
      check({tag, "_residual"}, {16'd0, res}, 32'h800D);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [7:0] hs_tab [0:3];
   int base, d0, r0, u0, s0, k;
   logic [15:0] rr;
   logic [7:0]  e0;

   initial begin
      hs_tab[0] = 8'hD2; hs_tab[1] = 8'h5A; hs_tab[2] = 8'h1E; hs_tab[3] = 8'h96;

      // Reset state
      repeat (3) @(negedge clk);
      #4;
      check("rst_valid",    {31'd0, tx_valid},    0);
      check("rst_data",     {24'd0, tx_data},     0);
      check("rst_rd",       {31'd0, data_rd},     0);
      check("rst_busy",     {31'd0, tx_busy},     0);
      check("rst_done",     {31'd0, tx_done},     0);
      check("rst_underrun", {31'd0, tx_underrun}, 0);
      check("rst_timeout",  {31'd0, tx_timeout},  0);
      @(posedge clk); #1 rst = 1'b1;

      // ACK: one byte on the cycle after the request, done with it
      base = byte_cnt; d0 = done_cnt;
      start_hs(2'd0);
      @(negedge clk); #4;
      check("ack_valid", {31'd0, tx_valid}, 1);
      check("ack_byte",  {24'd0, tx_data},  32'hD2);
      check("ack_done",  {31'd0, tx_done},  1);
      check("ack_busy",  {31'd0, tx_busy},  1);
      @(negedge clk); #4;
      check("ack_busy_after",  {31'd0, tx_busy},  0);
      check("ack_valid_after", {31'd0, tx_valid}, 0);
      check("ack_nbytes", byte_cnt - base, 1);
      check("ack_ndone",  done_cnt - d0,   1);

      // Remaining handshake PIDs
      for (int s = 1; s < 4; s++) begin
         base = byte_cnt;
         start_hs(2'(s));
         wait_idle("hs_idle", 10);
         check("hs_nbytes", byte_cnt - base, 1);
         check("hs_byte", {24'd0, blog[base[7:0]]}, {24'd0, hs_tab[s]});
      end

      // Zero-length DATA1; a handshake request mid-packet is ignored
      base = byte_cnt; d0 = done_cnt;
      start_data(2'd1, 1'b1, 1'b0);
      send_hs = 1'b1;
      @(posedge clk); #1 send_hs = 1'b0;
      wait_idle("zlp_idle", 20);
      @(negedge clk); #4;
      check("zlp_stay_idle", {31'd0, tx_busy}, 0);
      check("zlp_nbytes", byte_cnt - base, 3);
      check("zlp_pid",  {24'd0, blog[base[7:0]]},      32'h4B);
      check("zlp_crc0", {24'd0, blog[8'(base + 1)]},   32'h00);
      check("zlp_crc1", {24'd0, blog[8'(base + 2)]},   32'h00);
      check("zlp_ndone", done_cnt - d0, 1);

      // send_data wins over send_hs
      base = byte_cnt;
      start_data(2'd3, 1'b1, 1'b1);
      wait_idle("prio_idle", 20);
      check("prio_nbytes", byte_cnt - base, 3);
      check("prio_pid", {24'd0, blog[base[7:0]]}, 32'h0F);

      // 3-byte payload with tx_ready toggling every cycle
      pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay_len = 3;
      rdy_mode = 1;
      base = byte_cnt; d0 = done_cnt; r0 = rd_cnt; s0 = stab_viol;
      start_data(2'd0, 1'b0, 1'b0);
      wait_idle("p3_idle", 100);
      rdy_mode = 0;
      check_data_pkt("p3", base, 8'hC3, 3);
      check("p3_nrd",   rd_cnt - r0,     3);
      check("p3_ndone", done_cnt - d0,   1);
      check("p3_hold",  stab_viol - s0,  0);

      // One empty cycle mid-payload does not abort
      pay[0] = 8'h00; pay[1] = 8'hFF; pay_len = 2;
      base = byte_cnt; d0 = done_cnt; u0 = und_cnt;
      start_data(2'd2, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1 gap_en = 1'b1;
      @(posedge clk); #1 gap_en = 1'b0;
      wait_idle("gap1_idle", 30);
      check_data_pkt("gap1", base, 8'h87, 2);
      check("gap1_nund",  und_cnt - u0,  0);
      check("gap1_ndone", done_cnt - d0, 1);

      // Two empty cycles abort with tx_underrun and no tx_done
      pay[0] = 8'h0A; pay[1] = 8'h0B; pay[2] = 8'h0C; pay[3] = 8'h0D; pay_len = 4;
      base = byte_cnt; d0 = done_cnt; u0 = und_cnt; r0 = rd_cnt;
      start_data(2'd1, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1 gap_en = 1'b1;
      @(negedge clk); #4;
      check("und_first_miss", {31'd0, tx_underrun}, 0);
      check("und_first_busy", {31'd0, tx_busy},     1);
      @(negedge clk); #4;
      check("und_pulse", {31'd0, tx_underrun}, 1);
      check("und_valid", {31'd0, tx_valid},    0);
      @(negedge clk); #4;
      check("und_idle", {31'd0, tx_busy}, 0);
      gap_en = 1'b0;
      check("und_nund",   und_cnt - u0,   1);
      check("und_ndone",  done_cnt - d0,  0);
      check("und_nbytes", byte_cnt - base, 2);
      check("und_nrd",    rd_cnt - r0,    1);
      check("und_byte1",  {24'd0, blog[8'(base + 1)]}, 32'h0A);

      // Reset while stalled in CRC_LO, then a clean ACK
      pay[0] = 8'h01; pay_len = 1;
      rr = crc_std(16'hFFFF, 8'h01);
      for (int j = 0; j < 8; j++) e0[j] = ~rr[15 - j];
      start_data(2'd0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1 rdy_mode = 2;
      @(negedge clk); #4;
      check("crclo_valid", {31'd0, tx_valid}, 1);
      check("crclo_byte",  {24'd0, tx_data},  {24'd0, e0});
      rst = 1'b0;
      #1;
      check("arst_valid", {31'd0, tx_valid}, 0);
      check("arst_data",  {24'd0, tx_data},  0);
      check("arst_busy",  {31'd0, tx_busy},  0);
      check("arst_rd",    {31'd0, data_rd},  0);
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      base = byte_cnt; d0 = done_cnt;
      start_hs(2'd0);
      wait_idle("post_rst_idle", 10);
      check("post_rst_nbytes", byte_cnt - base, 1);
      check("post_rst_byte", {24'd0, blog[base[7:0]]}, 32'hD2);
      check("post_rst_ndone", done_cnt - d0, 1);

`ifdef USBF_PA_TX_TIMEOUT_EN
      // Stalled handshake times out 255 cycles after tx_valid rises
      rdy_mode = 2; d0 = done_cnt;
      start_hs(2'd0);
      k = 0;
      while (k < 400) begin
         @(negedge clk); #4;
         if (tx_timeout) break;
         k++;
      end
      check("to_cycle", k, 255);
      @(negedge clk); #4;
      check("to_idle",  {31'd0, tx_busy},  0);
      check("to_valid", {31'd0, tx_valid}, 0);
      check("to_ndone", done_cnt - d0, 0);
      rdy_mode = 0;
`else
      // Without the timeout the stall simply persists
      rdy_mode = 2; d0 = done_cnt;
      start_hs(2'd0);
      repeat (300) @(negedge clk);
      #4;
      check("stall_busy",    {31'd0, tx_busy},    1);
      check("stall_valid",   {31'd0, tx_valid},   1);
      check("stall_timeout", {31'd0, tx_timeout}, 0);
      rdy_mode = 0;
      wait_idle("stall_idle", 10);
      check("stall_ndone", done_cnt - d0, 1);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
